i2c_addr_match_fsm: RTL and testbench

//  Front end of the I2C slave address decoder. Consumes synchronized SCL/SDA.

---
 rtl/i2c_addr_match_fsm_if.sv | 23 ++
 rtl/i2c_addr_match_fsm.sv | 162 ++++++++++++++++
 tb/tb_i2c_addr_match_fsm.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_addr_match_fsm_if.sv
// Bus bundle between the I2C front end and its environment: synchronized SCL/SDA in,
// ACK drive and address-phase status out.
interface i2c_addr_match_fsm_if;
  logic       scl_sync;
  logic       sda_sync;
  logic       sda_oe;
  logic       addr_match;
  logic       rw;
  logic       addressed;
  logic       start_det;
  logic       stop_det;
  logic [2:0] bit_cnt;

  modport master (
    output scl_sync, sda_sync,
    input  sda_oe, addr_match, rw, addressed, start_det, stop_det, bit_cnt
  );

  modport slave (
    input  scl_sync, sda_sync,
    output sda_oe, addr_match, rw, addressed, start_det, stop_det, bit_cnt
  );
endinterface

// File: rtl/i2c_addr_match_fsm.sv
// I2C slave address front end: START/STOP detection, address byte shift-in,
// address compare and ACK drive during the 9th SCL clock.
module i2c_addr_match_fsm #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter bit         GEN_CALL_EN = 1'b0
) (
  input  logic                 FPGA_clk,
  input  logic                 rst_n,
  i2c_addr_match_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ACK_WAIT = 3'd2,
    ST_ACK      = 3'd3,
    ST_SEL      = 3'd4,
    ST_IGNORE   = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic       scl_q, sda_q;
  logic [6:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       rw_q, rw_d;
  logic       addressed_q, addressed_d;
  logic       sda_oe_q, sda_oe_d;
  logic       addr_match_q, addr_match_d;
  logic       start_det_q, start_det_d;
  logic       stop_det_q, stop_det_d;

  logic       scl_rise_s, scl_fall_s, start_s, stop_s;
  logic [7:0] byte_s;
  logic       match_s;

  assign scl_rise_s = bus.scl_sync & ~scl_q;
  assign scl_fall_s = ~bus.scl_sync & scl_q;
  assign start_s    = bus.scl_sync & scl_q & sda_q & ~bus.sda_sync;
  assign stop_s     = bus.scl_sync & scl_q & ~sda_q & bus.sda_sync;

  // Byte as it will stand once the current SDA sample is shifted in.
  assign byte_s  = {shift_q, bus.sda_sync};
  assign match_s = (byte_s[7:1] == SLAVE_ADDR) ||
                   ((GEN_CALL_EN == 1'b1) && (byte_s[7:1] == 7'h00));

  // Next-state and output decode; STOP outranks START, which outranks SCL edges.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    rw_d         = rw_q;
    addressed_d  = addressed_q;
    sda_oe_d     = sda_oe_q;
    addr_match_d = 1'b0;
    start_det_d  = start_s;
    stop_det_d   = stop_s;

    if (stop_s) begin
      state_d     = ST_IDLE;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else if (start_s) begin
      state_d     = ST_ADDR;
      bit_cnt_d   = 3'd0;
      shift_d     = 7'd0;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ADDR: begin
          if (scl_rise_s) begin
            shift_d   = byte_s[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (match_s) begin
                state_d      = ST_ACK_WAIT;
                rw_d         = byte_s[0];
                addr_match_d = 1'b1;
              end else begin
                state_d = ST_IGNORE;
              end
            end else begin
              state_d = ST_ADDR;
            end
          end else begin
            state_d = ST_ADDR;
          end
        end
        ST_ACK_WAIT: begin
          if (scl_fall_s) begin
            sda_oe_d    = 1'b1;
            addressed_d = 1'b1;
            state_d     = ST_ACK;
          end else begin
            state_d = ST_ACK_WAIT;
          end
        end
        ST_ACK: begin
          if (scl_fall_s) begin
            sda_oe_d = 1'b0;
            state_d  = ST_SEL;
          end else begin
            state_d = ST_ACK;
          end
        end
        ST_SEL: begin
          addressed_d = 1'b1;
          sda_oe_d    = 1'b0;
        end
        ST_IGNORE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d     = ST_IDLE;
          sda_oe_d    = 1'b0;
          addressed_d = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge FPGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      scl_q        <= 1'b1;
      sda_q        <= 1'b1;
      shift_q      <= 7'd0;
      bit_cnt_q    <= 3'd0;
      rw_q         <= 1'b0;
      addressed_q  <= 1'b0;
      sda_oe_q     <= 1'b0;
      addr_match_q <= 1'b0;
      start_det_q  <= 1'b0;
      stop_det_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      scl_q        <= bus.scl_sync;
      sda_q        <= bus.sda_sync;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      rw_q         <= rw_d;
      addressed_q  <= addressed_d;
      sda_oe_q     <= sda_oe_d;
      addr_match_q <= addr_match_d;
      start_det_q  <= start_det_d;
      stop_det_q   <= stop_det_d;
    end
  end

  assign bus.sda_oe     = sda_oe_q;
  assign bus.addr_match = addr_match_q;
  assign bus.rw         = rw_q;
  assign bus.addressed  = addressed_q;
  assign bus.start_det  = start_det_q;
  assign bus.stop_det   = stop_det_q;
  assign bus.bit_cnt    = bit_cnt_q;

endmodule

// File: tb/tb_i2c_addr_match_fsm.sv
// Bench for i2c_addr_match_fsm: two instances (general call off/on) share one bus and are
// checked against a transaction-level address-match model.
module tb_i2c_addr_match_fsm;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic scl   = 1'b1;
  logic sda   = 1'b1;

  always #5 clk = ~clk;

  i2c_addr_match_fsm_if b0 ();
  i2c_addr_match_fsm_if b1 ();

  assign b0.scl_sync = scl;
  assign b0.sda_sync = sda;
  assign b1.scl_sync = scl;
  assign b1.sda_sync = sda;

  i2c_addr_match_fsm #(.SLAVE_ADDR(7'h42), .GEN_CALL_EN(1'b0)) dut0 (
    .FPGA_clk(clk), .rst_n(rst_n), .bus(b0));
  i2c_addr_match_fsm #(.SLAVE_ADDR(7'h42), .GEN_CALL_EN(1'b1)) dut1 (
    .FPGA_clk(clk), .rst_n(rst_n), .bus(b1));

  logic [1:0] am, rwo, adr, oe, sd, pd;
  logic [2:0] bc [2];
  assign am    = {b1.addr_match, b0.addr_match};
  assign rwo   = {b1.rw, b0.rw};
  assign adr   = {b1.addressed, b0.addressed};
  assign oe    = {b1.sda_oe, b0.sda_oe};
  assign sd    = {b1.start_det, b0.start_det};
  assign pd    = {b1.stop_det, b0.stop_det};
  assign bc[0] = b0.bit_cnt;
  assign bc[1] = b1.bit_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int st_cnt [2] = '{0, 0};
  int sp_cnt [2] = '{0, 0};
  int oe_cnt [2] = '{0, 0};
  int viol   [2] = '{0, 0};
  int tl = 3;
  int th = 3;
  logic exp_rw [2] = '{1'b0, 1'b0};

  // Pulse/level counters and bus-level invariants sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (sd[d]) st_cnt[d] <= st_cnt[d] + 1;
        if (pd[d]) sp_cnt[d] <= sp_cnt[d] + 1;
        if (oe[d]) oe_cnt[d] <= oe_cnt[d] + 1;
        if ((sd[d] && oe[d]) || (oe[d] && !adr[d]) || (am[d] && oe[d]))
          viol[d] <= viol[d] + 1;
      end
    end
  end

  function automatic bit ref_match(input logic [7:0] b, input bit gen);
    return ((b >> 1) == 8'h42) || (gen && ((b >> 1) == 8'h00));
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic phase(input logic s, input logic v, input int n);
    @(posedge clk);
    #1;
    scl = s;
    sda = v;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic do_start();
    int s0 [2];
    s0 = st_cnt;
    phase(1'b0, 1'b1, 2);
    phase(1'b1, 1'b1, th);
    phase(1'b1, 1'b0, th);
    phase(1'b0, 1'b0, tl);
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("start_det_pulses", d, st_cnt[d] - s0[d], 1);
      chk("bit_cnt_after_start", d, bc[d], 0);
      chk("addressed_after_start", d, adr[d], 0);
      chk("sda_oe_after_start", d, oe[d], 0);
    end
  endtask

  task automatic do_stop();
    int p0 [2];
    p0 = sp_cnt;
    phase(1'b0, 1'b0, tl);
    phase(1'b1, 1'b0, th);
    phase(1'b1, 1'b1, tl);
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("stop_det_pulses", d, sp_cnt[d] - p0[d], 1);
      chk("addressed_after_stop", d, adr[d], 0);
      chk("sda_oe_after_stop", d, oe[d], 0);
      chk("rw_after_stop", d, rwo[d], exp_rw[d]);
    end
  endtask

  // Shifts out nbits MSB-first; checks bit_cnt and the addr_match pulse after every rise.
  task automatic send_bits(input logic [7:0] b, input int nbits, input bit [1:0] m);
    for (int i = 0; i < nbits; i++) begin
      phase(1'b0, b[7-i], tl);
      @(posedge clk);
      #1;
      scl = 1'b1;
      @(negedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk("bit_cnt", d, bc[d], (i + 1) % 8);
        chk("addr_match_pulse", d, am[d], (i == 7) ? m[d] : 1'b0);
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk("addr_match_drop", d, am[d], 0);
      repeat (th - 3) @(posedge clk);
    end
  endtask

  // ending: 0 = STOP, 1 = leave for repeated START, 2 = leave inside the ACK clock
  task automatic xfer(input logic [7:0] b, input int ending);
    bit [1:0] m;
    int o0 [2];
    m[0] = ref_match(b, 1'b0);
    m[1] = ref_match(b, 1'b1);
    send_bits(b, 8, m);
    for (int d = 0; d < 2; d++) if (m[d]) exp_rw[d] = b[0];
    o0 = oe_cnt;
    phase(1'b0, 1'b1, tl);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("sda_oe_in_ack", d, oe[d], m[d]);
      chk("rw", d, rwo[d], exp_rw[d]);
    end
    if (ending != 2) begin
      phase(1'b1, 1'b1, th);
      phase(1'b0, 1'b1, tl);
      @(negedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
        chk("sda_oe_cycles", d, oe_cnt[d] - o0[d], m[d] ? (tl + th) : 0);
        chk("addressed", d, adr[d], m[d]);
        chk("sda_oe_released", d, oe[d], 0);
      end
      if (ending == 0) do_stop();
    end
  endtask

  initial begin
    logic [7:0] b;
    int mode;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_outputs", d, {am[d], rwo[d], adr[d], oe[d], sd[d], pd[d], bc[d]}, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    do_start(); xfer(8'h84, 0);
    do_start(); xfer(8'h85, 0);
    do_start(); xfer(8'h90, 0);
    do_start(); send_bits(8'h84, 4, 2'b00); do_stop();
    do_start(); xfer(8'h84, 1);
    do_start(); xfer(8'h85, 0);
    do_start(); xfer(8'h00, 0);
    do_start(); xfer(8'h01, 2);
    do_start(); xfer(8'h84, 0);

    // Asynchronous reset while the ACK is being driven.
    do_start();
    send_bits(8'h84, 8, 2'b11);
    phase(1'b0, 1'b1, tl);
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk("sda_oe_before_reset", d, oe[d], 1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_reset_outputs", d, {am[d], rwo[d], adr[d], oe[d], sd[d], pd[d], bc[d]}, 0);
      exp_rw[d] = 1'b0;
    end
    scl = 1'b1;
    sda = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    for (int k = 0; k < 30; k++) begin
      tl = $urandom_range(2, 5);
      th = $urandom_range(3, 5);
      case ($urandom_range(0, 4))
        0: b = 8'h84;
        1: b = 8'h85;
        2: b = 8'h00;
        3: b = 8'h01;
        default: b = 8'($urandom_range(0, 255));
      endcase
      mode = $urandom_range(0, 3);
      do_start();
      if (mode == 3) begin
        send_bits(b, $urandom_range(1, 7), 2'b00);
        do_stop();
      end else begin
        xfer(b, mode);
      end
    end
    do_stop();

    for (int d = 0; d < 2; d++) chk("bus_invariants", d, viol[d], 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
